// File: rtl/local_ni_if.sv
// Host/router-side signal bundle for local_ni.
// slave is the NI view; master is the host/router/testbench view.
interface local_ni_if;
  logic        tx_req_i;
  logic [3:0]  tx_dest_i;
  logic [2:0]  tx_len_i;
  logic        tx_ack_o;
  logic [14:0] tx_data_i;
  logic        tx_data_valid_i;
  logic        tx_data_ready_o;
  logic        credit_i;
  logic [16:0] flit_o;
  logic [16:0] flit_i;
  logic [16:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        consume_o;
  logic        rx_ovf_o;
  logic        rx_err_o;

  modport slave (
    input  tx_req_i, tx_dest_i, tx_len_i, tx_data_i, tx_data_valid_i,
           credit_i, flit_i, rx_ready_i,
    output tx_ack_o, tx_data_ready_o, flit_o, rx_data_o, rx_valid_o,
           consume_o, rx_ovf_o, rx_err_o
  );

  modport master (
    output tx_req_i, tx_dest_i, tx_len_i, tx_data_i, tx_data_valid_i,
           credit_i, flit_i, rx_ready_i,
    input  tx_ack_o, tx_data_ready_o, flit_o, rx_data_o, rx_valid_o,
           consume_o, rx_ovf_o, rx_err_o
  );
endinterface

// File: rtl/local_ni.sv
// Local network interface: credit-based packet TX, RX FIFO with overflow flag.
// Define LOCAL_NI_CHECK_EN to build the RX protocol checker driving rx_err_o.
//
// state    | meaning
// S_IDLE   | TX waiting for tx_req_i
// S_HEAD   | TX header pending, waits for a credit
// S_BODY   | TX body flits pending, waits for payload and credit
// C_HDR    | RX checker expects a header
// C_BODY   | RX checker expects r_cnt more body flits
// C_RESYNC | RX checker after an error, skipping bodies until a header
module local_ni #(
  parameter int ROUTER_ID = 12,
  parameter int CREDITS   = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic      clk,
  input  logic      rst,
  local_ni_if.slave bus
);

  localparam logic [3:0] SRC_ID   = 4'(ROUTER_ID);
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);
  localparam int         AW       = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} tx_state_t;

  tx_state_t   r_state, w_state_nxt;
  logic [3:0]  r_dest;
  logic [2:0]  r_len, r_rem, r_cred;
  logic [16:0] r_flit;
  logic        r_ack;
  logic        w_accept, w_issue_hdr, w_issue_body, w_issue, w_has_cred;

  assign w_has_cred = (r_cred != 3'd0);
  assign w_issue    = w_issue_hdr | w_issue_body;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue_hdr  = 1'b0;
    w_issue_body = 1'b0;
    case (r_state)
      S_IDLE: if (bus.tx_req_i) begin
        w_accept    = 1'b1;
        w_state_nxt = S_HEAD;
      end
      S_HEAD: if (w_has_cred) begin
        w_issue_hdr = 1'b1;
        w_state_nxt = (r_len != 3'd0) ? S_BODY : S_IDLE;
      end
      S_BODY: if (bus.tx_data_valid_i && w_has_cred) begin
        w_issue_body = 1'b1;
        if (r_rem == 3'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dest <= '0;
      r_len  <= '0;
      r_rem  <= '0;
      r_cred <= CRED_MAX;
      r_flit <= '0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_dest <= bus.tx_dest_i;
        r_len  <= bus.tx_len_i;
      end
      if (w_issue_hdr) begin
        r_flit <= {1'b1, 1'b1, r_dest, SRC_ID, r_len, 4'b0000};
        r_rem  <= r_len;
      end else if (w_issue_body) begin
        r_flit <= {1'b1, 1'b0, bus.tx_data_i};
        r_rem  <= r_rem - 3'd1;
      end else begin
        r_flit <= '0;
      end
      // Returned credits saturate so a spurious pulse cannot exceed the buffer depth.
      case ({w_issue, bus.credit_i})
        2'b10:   r_cred <= r_cred - 3'd1;
        2'b01:   if (r_cred != CRED_MAX) r_cred <= r_cred + 3'd1;
        default: r_cred <= r_cred;
      endcase
    end
  end

  assign bus.tx_ack_o        = r_ack;
  assign bus.tx_data_ready_o = w_issue_body;
  assign bus.flit_o          = r_flit;

  logic [16:0] r_mem [RX_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic        r_ovf;
  logic        w_empty, w_full, w_push, w_pop, w_wr_en;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = bus.flit_i[16];
  assign w_pop   = !w_empty && bus.rx_ready_i;
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= bus.flit_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      if (w_push && !w_wr_en) r_ovf <= 1'b1;
    end
  end

  assign bus.rx_data_o  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign bus.rx_valid_o = !w_empty;
  assign bus.consume_o  = w_pop;
  assign bus.rx_ovf_o   = r_ovf;

`ifdef LOCAL_NI_CHECK_EN
  typedef enum logic [1:0] {C_HDR, C_BODY, C_RESYNC} chk_state_t;

  chk_state_t r_chk, w_chk_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_err, w_err;

  always_comb begin
    w_chk_nxt = r_chk;
    w_cnt_nxt = r_cnt;
    w_err     = 1'b0;
    if (bus.flit_i[16]) begin
      case (r_chk)
        C_BODY: begin
          if (bus.flit_i[15]) begin
            w_err     = 1'b1;
            w_chk_nxt = C_RESYNC;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt == 3'd1) w_chk_nxt = C_HDR;
          end
        end
        default: begin
          if (bus.flit_i[15]) begin
            if (bus.flit_i[14:11] != SRC_ID) begin
              w_err     = 1'b1;
              w_chk_nxt = C_RESYNC;
            end else if (bus.flit_i[6:4] != 3'd0) begin
              w_chk_nxt = C_BODY;
              w_cnt_nxt = bus.flit_i[6:4];
            end else begin
              w_chk_nxt = C_HDR;
            end
          end else if (r_chk == C_HDR) begin
            w_err     = 1'b1;
            w_chk_nxt = C_RESYNC;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chk <= C_HDR;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_chk <= w_chk_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_err;
    end
  end

  assign bus.rx_err_o = r_err;
`else
  assign bus.rx_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_local_ni.sv
// Self-checking bench for local_ni: TX/RX scoreboards, credit stall, reset abort.
module tb_local_ni;
  localparam int ROUTER_ID = 12;
  localparam int CREDITS   = 4;
  localparam int RX_DEPTH  = 4;
  localparam logic [3:0] SRC = 4'(ROUTER_ID);
`ifdef LOCAL_NI_CHECK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  local_ni_if bus();

  local_ni #(.ROUTER_ID(ROUTER_ID), .CREDITS(CREDITS), .RX_DEPTH(RX_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  int          tx_cnt = 0;
  logic [16:0] txq[$];
  logic [16:0] rxq[$];
  logic [14:0] host_q[$];
  logic        exp_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk_hdr(input logic [3:0] d, input logic [3:0] s, input logic [2:0] l);
    return {1'b1, 1'b1, d, s, l, 4'b0000};
  endfunction

  function automatic logic [16:0] mk_body(input logic [14:0] p);
    return {1'b1, 1'b0, p};
  endfunction

  // TX scoreboard: every valid flit_o must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.flit_o[16] === 1'b1) begin
      tx_cnt++;
      if (txq.size() == 0) chk("tx_extra", 32'(bus.flit_o), 32'h0);
      else                 chk("tx_flit", 32'(bus.flit_o), 32'(txq.pop_front()));
    end
  end

  // Host payload source: presents host_q head, drops it once the NI consumed it.
  initial begin
    logic cons;
    forever begin
      @(negedge clk);
      cons = bus.tx_data_ready_o;
      @(posedge clk);
      #1;
      if (cons && host_q.size() > 0) void'(host_q.pop_front());
      bus.tx_data_valid_i = (host_q.size() > 0);
      bus.tx_data_i       = (host_q.size() > 0) ? host_q[0] : 15'h0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic pulse_credit();
    bus.credit_i = 1'b1;
    @(posedge clk);
    #1;
    bus.credit_i = 1'b0;
  endtask

  task automatic wait_tx_drain(input int max);
    int i = 0;
    while (txq.size() > 0 && i < max) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("tx_drain", 32'(txq.size()), 32'd0);
  endtask

  task automatic request(input logic [3:0] d, input logic [2:0] l);
    bus.tx_dest_i = d;
    bus.tx_len_i  = l;
    bus.tx_req_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_req_i = 1'b0;
    @(negedge clk);
    chk("tx_ack", 32'(bus.tx_ack_o), 32'd1);
    @(negedge clk);
    chk("tx_ack_pulse", 32'(bus.tx_ack_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [3:0] d, input logic [2:0] l,
                          input logic [14:0] p0, input logic [14:0] p1, input logic [14:0] p2);
    logic [14:0] pl [3];
    pl = '{p0, p1, p2};
    txq.push_back(mk_hdr(d, SRC, l));
    for (int i = 0; i < int'(l); i++) begin
      host_q.push_back(pl[i]);
      txq.push_back(mk_body(pl[i]));
    end
    request(d, l);
    wait_tx_drain(40);
    repeat (int'(l) + 1) pulse_credit();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rxq.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // RX scoreboard step: drive one cycle, check outputs, then update the FIFO model.
  task automatic rx_cycle(input logic [16:0] f, input logic rdy);
    bus.flit_i     = f;
    bus.rx_ready_i = rdy;
    @(negedge clk);
    chk("rx_valid", 32'(bus.rx_valid_o), 32'(rxq.size() > 0));
    chk("rx_ovf", 32'(bus.rx_ovf_o), 32'(exp_ovf));
    chk("rx_consume", 32'(bus.consume_o), 32'(rdy && rxq.size() > 0));
    if (rxq.size() > 0) begin
      chk("rx_data", 32'(bus.rx_data_o), 32'(rxq[0]));
      if (rdy) void'(rxq.pop_front());
    end else begin
      chk("rx_data_empty", 32'(bus.rx_data_o), 32'h0);
    end
    if (f[16]) begin
      if (rxq.size() < RX_DEPTH) rxq.push_back(f);
      else                       exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.flit_i     = '0;
    bus.rx_ready_i = 1'b0;
  endtask

  initial begin
    int base;
    int i;
    bus.tx_req_i   = 1'b0;
    bus.tx_dest_i  = '0;
    bus.tx_len_i   = '0;
    bus.credit_i   = 1'b0;
    bus.flit_i     = '0;
    bus.rx_ready_i = 1'b0;
    exp_ovf        = 1'b0;
    rst            = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flit_o", 32'(bus.flit_o), 32'h0);
    chk("rst_tx_ack", 32'(bus.tx_ack_o), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_data_ready_o), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data_o), 32'h0);
    chk("rst_consume", 32'(bus.consume_o), 32'd0);
    chk("rst_ovf", 32'(bus.rx_ovf_o), 32'd0);
    chk("rst_err", 32'(bus.rx_err_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    send_pkt(4'd5, 3'd2, 15'h1234, 15'h0042, 15'h0);
    send_pkt(4'd9, 3'd0, 15'h0, 15'h0, 15'h0);
    send_pkt(4'd12, 3'd3, 15'h7FFF, 15'h0000, 15'h5555);
    for (int k = 0; k < 4; k++)
      send_pkt(4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
               15'($urandom), 15'($urandom), 15'($urandom));

    // Credit exhaustion: extra returns saturate, so only CREDITS flits go out.
    base = tx_cnt;
    pulse_credit();
    pulse_credit();
    txq.push_back(mk_hdr(4'd2, SRC, 3'd5));
    for (int k = 0; k < 5; k++) begin
      host_q.push_back(15'h100 + 15'(k));
      txq.push_back(mk_body(15'h100 + 15'(k)));
    end
    request(4'd2, 3'd5);
    repeat (12) @(posedge clk);
    #1;
    chk("stall_cnt", 32'(tx_cnt - base), 32'd4);
    bus.tx_dest_i = 4'd1;
    bus.tx_len_i  = 3'd0;
    bus.tx_req_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_req_i = 1'b0;
    @(negedge clk);
    chk("ack_busy", 32'(bus.tx_ack_o), 32'd0);
    @(posedge clk);
    #1;
    pulse_credit();
    chk("cred_wait", 32'(bus.flit_o[16]), 32'd0);
    @(posedge clk);
    #2;
    chk("cred_5th", 32'(bus.flit_o), 32'(mk_body(15'h103)));
    @(posedge clk);
    #1;
    repeat (5) pulse_credit();
    wait_tx_drain(40);
    chk("pkt6_cnt", 32'(tx_cnt - base), 32'd6);

    // Reset in BODY with two flits outstanding.
    txq.push_back(mk_hdr(4'd6, SRC, 3'd3));
    host_q.push_back(15'h2AA);
    txq.push_back(mk_body(15'h2AA));
    request(4'd6, 3'd3);
    i = 0;
    while (bus.flit_o !== mk_body(15'h2AA) && i < 30) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("rst_setup", 32'(bus.flit_o), 32'(mk_body(15'h2AA)));
    rst = 1'b0;
    #1;
    chk("rst_mid_flit", 32'(bus.flit_o), 32'h0);
    chk("rst_mid_ready", 32'(bus.tx_data_ready_o), 32'd0);
    txq.delete();
    host_q.delete();
    base = tx_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    host_q.push_back(15'h011);
    host_q.push_back(15'h022);
    host_q.push_back(15'h033);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_residual", 32'(tx_cnt - base), 32'd0);
    chk("rst_hostq", 32'(host_q.size()), 32'd3);
    host_q.delete();
    @(posedge clk);
    #1;
    send_pkt(4'd3, 3'd3, 15'h0A1, 15'h0B2, 15'h0C3);

    // RX overflow: five pushes into a four-deep FIFO, then drain.
    do_reset();
    rx_cycle(mk_hdr(SRC, 4'd3, 3'd4), 1'b0);
    for (int k = 0; k < 4; k++) rx_cycle(mk_body(15'h600 + 15'(k)), 1'b0);
    rx_cycle('0, 1'b0);
    for (int k = 0; k < 4; k++) rx_cycle('0, 1'b1);
    rx_cycle('0, 1'b1);

    // Full FIFO with simultaneous push and pop: nothing dropped.
    do_reset();
    for (int k = 0; k < 4; k++) rx_cycle(mk_hdr(SRC, 4'(k), 3'd0), 1'b0);
    rx_cycle(mk_hdr(SRC, 4'd9, 3'd0), 1'b1);
    rx_cycle('0, 1'b0);
    for (int k = 0; k < 4; k++) rx_cycle('0, 1'b1);
    rx_cycle('0, 1'b0);

    // RX protocol checker.
    do_reset();
    rx_cycle(mk_body(15'h077), 1'b0);
    rx_cycle('0, 1'b0);
    chk("err_body_first", 32'(bus.rx_err_o), 32'(CHK_ON));
    do_reset();
    rx_cycle(mk_hdr(SRC, 4'd1, 3'd1), 1'b0);
    rx_cycle(mk_body(15'h0AB), 1'b0);
    rx_cycle('0, 1'b0);
    chk("err_clean", 32'(bus.rx_err_o), 32'd0);
    rx_cycle(mk_hdr(4'd3, 4'd1, 3'd0), 1'b0);
    rx_cycle('0, 1'b0);
    chk("err_bad_dest", 32'(bus.rx_err_o), 32'(CHK_ON));
    do_reset();
    rx_cycle(mk_hdr(SRC, 4'd1, 3'd2), 1'b0);
    rx_cycle(mk_hdr(SRC, 4'd1, 3'd0), 1'b0);
    rx_cycle('0, 1'b0);
    chk("err_hdr_in_body", 32'(bus.rx_err_o), 32'(CHK_ON));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
